// File: rtl/cpu_axi_bridge_if.sv
// Bus bundles for the CPU-to-AXI bridge: CPU read port, CPU
// read/write port, and the single-outstanding AXI master link.
interface cpu_rd_if;
  logic        req;
  logic [31:0] addr;
  logic        addr_ok;
  logic        data_ok;
  logic [31:0] rdata;

  modport master (
    output req, addr,
    input  addr_ok, data_ok, rdata
  );
  modport slave (
    input  req, addr,
    output addr_ok, data_ok, rdata
  );
endinterface

interface cpu_rw_if;
  logic        req;
  logic        wr;
  logic [3:0]  wstrb;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        addr_ok;
  logic        data_ok;
  logic [31:0] rdata;

  modport master (
    output req, wr, wstrb, addr, wdata,
    input  addr_ok, data_ok, rdata
  );
  modport slave (
    input  req, wr, wstrb, addr, wdata,
    output addr_ok, data_ok, rdata
  );
endinterface

interface axi_if;
  logic [31:0] araddr;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic        rvalid;
  logic        rready;
  logic [31:0] awaddr;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid;
  logic        wready;
  logic        bvalid;
  logic        bready;

  modport master (
    output araddr, arvalid, rready,
    output awaddr, awvalid, wdata, wstrb, wvalid, bready,
    input  arready, rdata, rvalid, awready, wready, bvalid
  );
  modport slave (
    input  araddr, arvalid, rready,
    input  awaddr, awvalid, wdata, wstrb, wvalid, bready,
    output arready, rdata, rvalid, awready, wready, bvalid
  );
endinterface

// File: rtl/cpu_axi_bridge.sv
// Merges the CPU instruction and data ports onto one AXI master,
// one transaction in flight at a time.
module cpu_axi_bridge #(
  parameter bit DATA_PRIO = 1'b1
) (
  input  logic     clk,
  input  logic     reset,
  cpu_rd_if.slave  inst,
  cpu_rw_if.slave  data,
  axi_if.master    axi
);

  typedef enum logic [2:0] {
    IDLE,
    RD_A,
    RD_D,
    WR_AW,
    WR_B,
    RESP
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic        r_src;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [3:0]  r_wstrb;
  logic        r_aw_done;
  logic        r_w_done;
  logic [31:0] r_inst_rdata;
  logic [31:0] r_data_rdata;

  logic w_pick_d;
  logic w_pick_i;
  logic w_aw_hs;
  logic w_w_hs;
  logic w_take;

  assign w_pick_d = data.req & (DATA_PRIO | ~inst.req);
  assign w_pick_i = inst.req & ~w_pick_d;
  assign w_take   = (r_state == IDLE) & (w_pick_d | w_pick_i);
  assign w_aw_hs  = axi.awvalid & axi.awready;
  assign w_w_hs   = axi.wvalid & axi.wready;

  assign axi.araddr = r_addr;
  assign axi.awaddr = r_addr;
  assign axi.wdata  = r_wdata;
  assign axi.wstrb  = r_wstrb;
  assign inst.rdata = r_inst_rdata;
  assign data.rdata = r_data_rdata;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next       = r_state;
    axi.arvalid  = 1'b0;
    axi.rready   = 1'b0;
    axi.awvalid  = 1'b0;
    axi.wvalid   = 1'b0;
    axi.bready   = 1'b0;
    inst.addr_ok = 1'b0;
    data.addr_ok = 1'b0;
    inst.data_ok = 1'b0;
    data.data_ok = 1'b0;
    unique case (r_state)
      IDLE: begin
        data.addr_ok = w_pick_d;
        inst.addr_ok = w_pick_i;
        if (w_pick_d) begin
          w_next = data.wr ? WR_AW : RD_A;
        end else if (w_pick_i) begin
          w_next = RD_A;
        end
      end
      RD_A: begin
        axi.arvalid = 1'b1;
        if (axi.arready) w_next = RD_D;
      end
      RD_D: begin
        axi.rready = 1'b1;
        if (axi.rvalid) w_next = RESP;
      end
      WR_AW: begin
        axi.awvalid = ~r_aw_done;
        axi.wvalid  = ~r_w_done;
        // AW and W may complete in either order or together
        if ((r_aw_done | w_aw_hs) & (r_w_done | w_w_hs)) begin
          w_next = WR_B;
        end
      end
      WR_B: begin
        axi.bready = 1'b1;
        if (axi.bvalid) w_next = RESP;
      end
      RESP: begin
        inst.data_ok = ~r_src;
        data.data_ok = r_src;
        w_next       = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_src        <= 1'b0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_wstrb      <= '0;
      r_aw_done    <= 1'b0;
      r_w_done     <= 1'b0;
      r_inst_rdata <= '0;
      r_data_rdata <= '0;
    end else begin
      if (w_take) begin
        r_src     <= w_pick_d;
        r_addr    <= w_pick_d ? data.addr : inst.addr;
        r_wdata   <= data.wdata;
        r_wstrb   <= data.wstrb;
        r_aw_done <= 1'b0;
        r_w_done  <= 1'b0;
      end
      if (r_state == WR_AW) begin
        if (w_aw_hs) r_aw_done <= 1'b1;
        if (w_w_hs)  r_w_done  <= 1'b1;
      end
      if ((r_state == RD_D) && axi.rvalid) begin
        if (r_src) begin
          r_data_rdata <= axi.rdata;
        end else begin
          r_inst_rdata <= axi.rdata;
        end
      end
    end
  end

endmodule

// File: tb/tb_cpu_axi_bridge.sv
// Directed and random-traffic bench for cpu_axi_bridge with a
// manual AXI slave for the directed cases and a random one after.
module tb_cpu_axi_bridge;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  cpu_rd_if inst_if ();
  cpu_rw_if data_if ();
  axi_if    axi ();

  cpu_axi_bridge #(.DATA_PRIO(1'b1)) dut (
    .clk   (clk),
    .reset (reset),
    .inst  (inst_if),
    .data  (data_if),
    .axi   (axi)
  );

  logic        auto_en = 1'b0;
  logic        cnt_en = 1'b0;
  logic        m_arready, m_rvalid, m_awready, m_wready, m_bvalid;
  logic [31:0] m_rdata;
  logic        a_arready, a_rvalid, a_awready, a_wready, a_bvalid;
  logic [31:0] a_rdata;

  assign axi.arready = auto_en ? a_arready : m_arready;
  assign axi.rvalid  = auto_en ? a_rvalid  : m_rvalid;
  assign axi.rdata   = auto_en ? a_rdata   : m_rdata;
  assign axi.awready = auto_en ? a_awready : m_awready;
  assign axi.wready  = auto_en ? a_wready  : m_wready;
  assign axi.bvalid  = auto_en ? a_bvalid  : m_bvalid;

  int n_chk = 0;
  int n_bad = 0;
  int n_aok = 0;
  int n_dok = 0;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Random slave: decisions at negedge, handshakes land on next posedge
  logic [31:0] smem [8];
  logic [31:0] ref_mem [8];
  logic        r_pend, b_pend, got_aw, got_w;
  logic [2:0]  rd_idx, wa;
  logic [31:0] wd_s;
  logic [3:0]  ws_s;

  initial begin : slave
    r_pend = 0; b_pend = 0; got_aw = 0; got_w = 0;
    rd_idx = 0; wa = 0; wd_s = 0; ws_s = 0;
    a_arready = 0; a_rvalid = 0; a_rdata = 0;
    a_awready = 0; a_wready = 0; a_bvalid = 0;
    for (int i = 0; i < 8; i++) begin
      smem[i] = 0;
      ref_mem[i] = 0;
    end
    forever begin
      @(negedge clk);
      if (auto_en) begin
        a_rvalid = r_pend && ($urandom_range(0, 1) == 1);
        a_rdata  = smem[rd_idx];
        if (a_rvalid && axi.rready) r_pend = 0;
        a_arready = 1'($urandom_range(0, 1));
        if (axi.arvalid && a_arready) begin
          r_pend = 1;
          rd_idx = axi.araddr[4:2];
        end
        a_bvalid = b_pend && ($urandom_range(0, 1) == 1);
        if (a_bvalid && axi.bready) b_pend = 0;
        a_awready = 1'($urandom_range(0, 1));
        if (axi.awvalid && a_awready) begin
          got_aw = 1;
          wa = axi.awaddr[4:2];
        end
        a_wready = 1'($urandom_range(0, 1));
        if (axi.wvalid && a_wready) begin
          got_w = 1;
          wd_s = axi.wdata;
          ws_s = axi.wstrb;
        end
        if (got_aw && got_w) begin
          for (int b = 0; b < 4; b++)
            if (ws_s[b]) smem[wa][8*b +: 8] = wd_s[8*b +: 8];
          b_pend = 1;
          got_aw = 0;
          got_w = 0;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (cnt_en) begin
      if (data_if.addr_ok) n_aok <= n_aok + 1;
      if (data_if.data_ok) n_dok <= n_dok + 1;
    end
  end

  logic [2:0]  idx;
  logic        wr;
  logic [3:0]  st;
  logic [31:0] wd;
  bit          ok;

  initial begin
    inst_if.req = 0; inst_if.addr = 0;
    data_if.req = 0; data_if.wr = 0; data_if.wstrb = 0;
    data_if.addr = 0; data_if.wdata = 0;
    m_arready = 0; m_rvalid = 0; m_rdata = 0;
    m_awready = 0; m_wready = 0; m_bvalid = 0;
    #1;
    check("rst_arvalid", 32'(axi.arvalid), 0);
    check("rst_ctl", 32'({axi.rready, axi.awvalid, axi.wvalid,
                          axi.bready, inst_if.addr_ok, data_if.addr_ok,
                          inst_if.data_ok, data_if.data_ok}), 0);
    check("rst_araddr", axi.araddr, 0);
    check("rst_wstrb", 32'(axi.wstrb), 0);
    check("rst_irdata", inst_if.rdata, 0);
    tick; tick;
    reset = 0;
    tick;

    // instruction fetch, minimum latency
    m_arready = 1;
    inst_if.req = 1; inst_if.addr = 32'hBFC0_0000;
    #1 check("t1_iaok", 32'(inst_if.addr_ok), 1);
    tick;
    inst_if.req = 0;
    check("t1_arvalid", 32'(axi.arvalid), 1);
    check("t1_araddr", axi.araddr, 32'hBFC0_0000);
    tick;
    check("t1_rready", 32'(axi.rready), 1);
    m_rvalid = 1; m_rdata = 32'h2401_0001;
    tick;
    m_rvalid = 0;
    check("t1_idok", 32'(inst_if.data_ok), 1);
    check("t1_irdata", inst_if.rdata, 32'h2401_0001);
    check("t1_ddok", 32'(data_if.data_ok), 0);
    tick;
    check("t1_pulse", 32'(inst_if.data_ok), 0);

    // simultaneous requests, data wins
    data_if.req = 1; data_if.wr = 0; data_if.addr = 32'h100;
    inst_if.req = 1; inst_if.addr = 32'h200;
    #1;
    check("t2_daok", 32'(data_if.addr_ok), 1);
    check("t2_iaok", 32'(inst_if.addr_ok), 0);
    tick;
    data_if.req = 0;
    #1;
    check("t2_araddr", axi.araddr, 32'h100);
    check("t2_iaok_busy", 32'(inst_if.addr_ok), 0);
    tick;
    m_rvalid = 1; m_rdata = 32'hCAFE_0001;
    tick;
    m_rvalid = 0;
    check("t2_ddok", 32'(data_if.data_ok), 1);
    check("t2_drdata", data_if.rdata, 32'hCAFE_0001);
    check("t2_iaok_resp", 32'(inst_if.addr_ok), 0);
    tick;
    check("t2_iaok_idle", 32'(inst_if.addr_ok), 1);
    tick;
    inst_if.req = 0;
    check("t2_araddr2", axi.araddr, 32'h200);
    tick;
    m_rvalid = 1; m_rdata = 32'h0BAD_0002;
    tick;
    m_rvalid = 0;
    check("t2_idok", 32'(inst_if.data_ok), 1);
    check("t2_irdata", inst_if.rdata, 32'h0BAD_0002);
    check("t2_drdata_hold", data_if.rdata, 32'hCAFE_0001);
    m_arready = 0;
    tick;

    // write with AW and W handshakes in different cycles
    data_if.req = 1; data_if.wr = 1; data_if.addr = 32'h40;
    data_if.wdata = 32'h1122_3344; data_if.wstrb = 4'h3;
    #1 check("t3_daok", 32'(data_if.addr_ok), 1);
    tick;
    data_if.req = 0; data_if.wr = 0; data_if.wstrb = 0;
    check("t3_awvalid", 32'(axi.awvalid), 1);
    check("t3_wvalid", 32'(axi.wvalid), 1);
    check("t3_awaddr", axi.awaddr, 32'h40);
    check("t3_wstrb", 32'(axi.wstrb), 32'h3);
    m_awready = 1;
    tick;
    m_awready = 0;
    check("t3_aw_drop", 32'(axi.awvalid), 0);
    check("t3_w_hold", 32'(axi.wvalid), 1);
    tick;
    check("t3_w_hold2", 32'(axi.wvalid), 1);
    check("t3_wdata", axi.wdata, 32'h1122_3344);
    m_wready = 1;
    tick;
    m_wready = 0;
    check("t3_w_drop", 32'(axi.wvalid), 0);
    check("t3_bready", 32'(axi.bready), 1);
    check("t3_ddok_early", 32'(data_if.data_ok), 0);
    m_bvalid = 1;
    tick;
    m_bvalid = 0;
    check("t3_ddok", 32'(data_if.data_ok), 1);
    check("t3_drdata_keep", data_if.rdata, 32'hCAFE_0001);
    tick;

    // AR stall for 5 cycles
    data_if.req = 1; data_if.addr = 32'h80;
    #1 check("t4_daok", 32'(data_if.addr_ok), 1);
    tick;
    data_if.req = 0;
    for (int k = 0; k < 5; k++) begin
      check("t4_arvalid", 32'(axi.arvalid), 1);
      check("t4_araddr", axi.araddr, 32'h80);
      check("t4_nodok", 32'(data_if.data_ok), 0);
      tick;
    end
    m_arready = 1;
    tick;
    m_arready = 0;
    check("t4_ar_drop", 32'(axi.arvalid), 0);
    check("t4_rready", 32'(axi.rready), 1);
    tick;
    check("t4_nodok2", 32'(data_if.data_ok), 0);
    m_rvalid = 1; m_rdata = 32'h5A5A_0004;
    tick;
    m_rvalid = 0;
    check("t4_ddok", 32'(data_if.data_ok), 1);
    check("t4_drdata", data_if.rdata, 32'h5A5A_0004);
    tick;

    // asynchronous reset while waiting in RD_D
    m_arready = 1;
    inst_if.req = 1; inst_if.addr = 32'h300;
    tick;
    inst_if.req = 0;
    tick;
    m_arready = 0;
    check("t5_pre_rready", 32'(axi.rready), 1);
    #2 reset = 1;
    #1;
    check("t5_rready", 32'(axi.rready), 0);
    check("t5_arvalid", 32'(axi.arvalid), 0);
    check("t5_dok", 32'({inst_if.data_ok, data_if.data_ok}), 0);
    check("t5_irdata", inst_if.rdata, 0);
    tick;
    reset = 0;
    tick;
    inst_if.req = 1; inst_if.addr = 32'h304;
    #1;
    check("t5_idle_aok", 32'(inst_if.addr_ok), 1);
    inst_if.req = 0;
    tick;
    check("t5_still_idle", 32'(axi.arvalid), 0);

    // random back-to-back traffic
    auto_en = 1;
    cnt_en = 1;
    for (int i = 0; i < 100; i++) begin
      idx = 3'($urandom_range(0, 7));
      wr  = 1'($urandom_range(0, 1));
      st  = 4'($urandom_range(1, 15));
      wd  = $urandom;
      data_if.req   = 1;
      data_if.wr    = wr;
      data_if.addr  = 32'h1000 + {27'd0, idx, 2'b00};
      data_if.wdata = wd;
      data_if.wstrb = wr ? st : 4'h0;
      ok = 0;
      for (int k = 0; k < 40 && !ok; k++) begin
        #1;
        if (data_if.addr_ok) ok = 1;
        tick;
      end
      data_if.req = 0;
      if (!ok) check("rnd_acc_tmo", 0, 1);
      if (wr)
        for (int b = 0; b < 4; b++)
          if (st[b]) ref_mem[idx][8*b +: 8] = wd[8*b +: 8];
      ok = 0;
      for (int k = 0; k < 60 && !ok; k++) begin
        if (data_if.data_ok) ok = 1;
        else tick;
      end
      if (!ok) check("rnd_rsp_tmo", 0, 1);
      else if (!wr) check("rnd_rd", data_if.rdata, ref_mem[idx]);
    end
    tick; tick; tick;
    cnt_en = 0;
    tick;
    check("rnd_n_aok", 32'(n_aok), 100);
    check("rnd_n_dok", 32'(n_dok), 100);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
